ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage -- pipeline execute stage with EX/MEM output register.
//
// Purpose:
//   Selects forwarded operands and runs the ALU (add, sub, and, or, slt)
//   as decoded from ALUOp/funct. The result and the pass-through control
//   fields are captured in the EX/MEM register. An optional iterative
//   unsigned multiplier (funct 011000) stalls the upstream pipeline for
//   33 cycles while it runs 32 shift-add steps.
//
// Configuration:
//   EX_STAGE_MULT_EN  defined   -> multiplier FSM built, stall_out live.
//                     undefined -> funct 011000 decodes as unknown
//                                  (result 0), stall_out tied to 0.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   synchronous, active-low reset
//   WB_in, M_in             writeback / memory control from ID/EX
//   ALUSrc_in               1: operand B = sign_extended_in
//   ALUOp_in                ALU op class (00 add, 01 sub, 11 and, 10 funct)
//   RegDst_in               1: destination rd, 0: destination rt
//   RDdata1_in, RDdata2_in  register operands
//   sign_extended_in        immediate operand
//   Inst_20_to_16_in (rt), Inst_15_to_11_in (rd), Inst_5_to_0_in (funct)
//   fwdA_in, fwdB_in        forwarding selects (10 EX/MEM, 01 MEM/WB)
//   exmem_fwd_data_in, memwb_fwd_data_in  forwarded values
//   WB_out, M_out, ALU_result_out, store_data_out, WriteReg_out, Zero_out
//                           registered EX/MEM outputs
//   stall_out               combinational; holds PC, IF/ID and ID/EX
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic        ALUSrc_in,
    input  logic [1:0]  ALUOp_in,
    input  logic        RegDst_in,
    input  logic [31:0] RDdata1_in,
    input  logic [31:0] RDdata2_in,
    input  logic [31:0] sign_extended_in,
    input  logic [4:0]  Inst_20_to_16_in,
    input  logic [4:0]  Inst_15_to_11_in,
    input  logic [5:0]  Inst_5_to_0_in,
    input  logic [1:0]  fwdA_in,
    input  logic [1:0]  fwdB_in,
    input  logic [31:0] exmem_fwd_data_in,
    input  logic [31:0] memwb_fwd_data_in,
    output logic [1:0]  WB_out,
    output logic [1:0]  M_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  WriteReg_out,
    output logic        Zero_out,
    output logic        stall_out
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MULT,
        ALU_NONE
    } alu_op_t;

    logic [31:0] op_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    alu_op_t     alu_op;
    logic [31:0] alu_result;
    logic [31:0] ex_result;
    logic [4:0]  write_reg;

    // Forwarding: 11 falls back to the register value like 00.
    always_comb begin
        op_a = RDdata1_in;
        case (fwdA_in)
            2'b10:   op_a = exmem_fwd_data_in;
            2'b01:   op_a = memwb_fwd_data_in;
            default: op_a = RDdata1_in;
        endcase
    end

    always_comb begin
        fwd_b = RDdata2_in;
        case (fwdB_in)
            2'b10:   fwd_b = exmem_fwd_data_in;
            2'b01:   fwd_b = memwb_fwd_data_in;
            default: fwd_b = RDdata2_in;
        endcase
    end

    assign op_b      = ALUSrc_in ? sign_extended_in : fwd_b;
    assign write_reg = RegDst_in ? Inst_15_to_11_in : Inst_20_to_16_in;

    always_comb begin
        alu_op = ALU_NONE;
        case (ALUOp_in)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            2'b11: alu_op = ALU_AND;
            default: begin
                case (Inst_5_to_0_in)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
`ifdef EX_STAGE_MULT_EN
                    6'b011000: alu_op = ALU_MULT;
`endif
                    default:   alu_op = ALU_NONE;
                endcase
            end
        endcase
    end

    // Mult yields 0 here; its product comes from the accumulator in DONE.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_SLT: alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

`ifdef EX_STAGE_MULT_EN
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

    mult_state_t state;
    mult_state_t state_next;
    logic [4:0]  cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] acc;
    logic        is_mult;
    logic        fsm_stall;

    assign is_mult = (alu_op == ALU_MULT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_mult) begin
                        mul_a <= op_a;
                        mul_b <= op_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    // One partial product per cycle; cnt wraps to 0 after 31.
                    acc <= acc + (mul_b[cnt] ? (mul_a << cnt) : '0);
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        fsm_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mult) begin
                    state_next = BUSY;
                    fsm_stall  = 1'b1;
                end
            end
            BUSY: begin
                fsm_stall = 1'b1;
                if (cnt == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ex_result = (state == DONE) ? acc : alu_result;
    assign stall_out = reset & fsm_stall;
`else
    assign ex_result = alu_result;
    assign stall_out = 1'b0;
`endif

    // EX/MEM register; a stall inserts a bubble downstream.
    always_ff @(posedge clk) begin
        if (!reset || stall_out) begin
            WB_out         <= '0;
            M_out          <= '0;
            ALU_result_out <= '0;
            store_data_out <= '0;
            WriteReg_out   <= '0;
            Zero_out       <= 1'b0;
        end else begin
            WB_out         <= WB_in;
            M_out          <= M_in;
            ALU_result_out <= ex_result;
            store_data_out <= fwd_b;
            WriteReg_out   <= write_reg;
            Zero_out       <= (ex_result == '0);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  WB_in;
    logic [1:0]  M_in;
    logic        ALUSrc_in;
    logic [1:0]  ALUOp_in;
    logic        RegDst_in;
    logic [31:0] RDdata1_in;
    logic [31:0] RDdata2_in;
    logic [31:0] sign_extended_in;
    logic [4:0]  Inst_20_to_16_in;
    logic [4:0]  Inst_15_to_11_in;
    logic [5:0]  Inst_5_to_0_in;
    logic [1:0]  fwdA_in;
    logic [1:0]  fwdB_in;
    logic [31:0] exmem_fwd_data_in;
    logic [31:0] memwb_fwd_data_in;
    logic [1:0]  WB_out;
    logic [1:0]  M_out;
    logic [31:0] ALU_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  WriteReg_out;
    logic        Zero_out;
    logic        stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk               (clk),
        .reset             (reset),
        .WB_in             (WB_in),
        .M_in              (M_in),
        .ALUSrc_in         (ALUSrc_in),
        .ALUOp_in          (ALUOp_in),
        .RegDst_in         (RegDst_in),
        .RDdata1_in        (RDdata1_in),
        .RDdata2_in        (RDdata2_in),
        .sign_extended_in  (sign_extended_in),
        .Inst_20_to_16_in  (Inst_20_to_16_in),
        .Inst_15_to_11_in  (Inst_15_to_11_in),
        .Inst_5_to_0_in    (Inst_5_to_0_in),
        .fwdA_in           (fwdA_in),
        .fwdB_in           (fwdB_in),
        .exmem_fwd_data_in (exmem_fwd_data_in),
        .memwb_fwd_data_in (memwb_fwd_data_in),
        .WB_out            (WB_out),
        .M_out             (M_out),
        .ALU_result_out    (ALU_result_out),
        .store_data_out    (store_data_out),
        .WriteReg_out      (WriteReg_out),
        .Zero_out          (Zero_out),
        .stall_out         (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rv,
                                         input logic [31:0] ex, input logic [31:0] mw);
        if (sel == 2'b10) return ex;
        if (sel == 2'b01) return mw;
        return rv;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a & b;
        case (fn)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2a:   return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        WB_in = '0; M_in = '0; ALUSrc_in = 1'b0; ALUOp_in = '0; RegDst_in = 1'b0;
        RDdata1_in = '0; RDdata2_in = '0; sign_extended_in = '0;
        Inst_20_to_16_in = '0; Inst_15_to_11_in = '0; Inst_5_to_0_in = '0;
        fwdA_in = '0; fwdB_in = '0; exmem_fwd_data_in = '0; memwb_fwd_data_in = '0;
    endtask

    // Predicts the EX/MEM contents from the present inputs, clocks once, compares.
    task automatic exec_check(input string tag);
        logic [31:0] a, fb, b, r;
        logic [4:0]  wr;
        logic [1:0]  wb, m;
        #1;
        a  = pick(fwdA_in, RDdata1_in, exmem_fwd_data_in, memwb_fwd_data_in);
        fb = pick(fwdB_in, RDdata2_in, exmem_fwd_data_in, memwb_fwd_data_in);
        b  = ALUSrc_in ? sign_extended_in : fb;
        r  = ref_alu(ALUOp_in, Inst_5_to_0_in, a, b);
        wr = RegDst_in ? Inst_15_to_11_in : Inst_20_to_16_in;
        wb = WB_in;
        m  = M_in;
        check({tag, ".stall"}, {31'b0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".res"},  ALU_result_out, r);
        check({tag, ".zero"}, {31'b0, Zero_out}, (r == 32'd0) ? 32'd1 : 32'd0);
        check({tag, ".sd"},   store_data_out, fb);
        check({tag, ".wr"},   {27'b0, WriteReg_out}, {27'b0, wr});
        check({tag, ".ctl"},  {28'b0, WB_out, M_out}, {28'b0, wb, m});
    endtask

`ifdef EX_STAGE_MULT_EN
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] prod;
        int cycles;
        prod = a * b;
        ALUOp_in = 2'b10; Inst_5_to_0_in = 6'b011000; ALUSrc_in = 1'b0;
        fwdA_in = 2'b00; fwdB_in = 2'b00; RDdata1_in = a; RDdata2_in = b;
        WB_in = 2'b11; M_in = 2'b10; RegDst_in = 1'b1; Inst_15_to_11_in = 5'd17;
        #1;
        check({tag, ".start"}, {31'b0, stall_out}, 32'd1);
        cycles = 0;
        while (stall_out && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            check({tag, ".bubble"}, {23'b0, WB_out, M_out, WriteReg_out}, 32'd0);
            check({tag, ".bres"}, ALU_result_out, 32'd0);
            if (cycles == 1) begin
                RDdata1_in = $urandom;
                RDdata2_in = $urandom;
            end
        end
        check({tag, ".cycles"}, cycles, 32'd33);
        @(posedge clk);
        #1;
        check({tag, ".prod"}, ALU_result_out, prod);
        check({tag, ".wb"}, {27'b0, WB_out, WriteReg_out}, {27'b0, 2'b11, 5'd17});
    endtask
`endif

    initial begin
        logic [5:0] functs [6];
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2a; functs[5] = 6'h3f;

        clear_inputs();
        WB_in = 2'b11; M_in = 2'b11; RDdata1_in = 32'h1234; RDdata2_in = 32'h1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out", {23'b0, WB_out, M_out, WriteReg_out}, 32'd0);
        check("rst.res", ALU_result_out | store_data_out, 32'd0);
        check("rst.zero", {31'b0, Zero_out}, 32'd0);
        check("rst.stall", {31'b0, stall_out}, 32'd0);
        reset = 1'b1;

        // sub 5-7 through funct decode
        clear_inputs();
        ALUOp_in = 2'b10; Inst_5_to_0_in = 6'b100010; RDdata1_in = 32'd5; RDdata2_in = 32'd7;
        exec_check("sub");
        check("sub.const", ALU_result_out, 32'hFFFFFFFE);
        check("sub.zero", {31'b0, Zero_out}, 32'd0);

        // forwarded A plus negative immediate yields zero
        clear_inputs();
        ALUSrc_in = 1'b1; sign_extended_in = 32'hFFFFFFFC; fwdA_in = 2'b10;
        exmem_fwd_data_in = 32'd4; RDdata1_in = 32'd99; RDdata2_in = 32'hCAFE0001;
        exec_check("addi");
        check("addi.const", ALU_result_out, 32'd0);
        check("addi.zero", {31'b0, Zero_out}, 32'd1);
        check("addi.sd", store_data_out, 32'hCAFE0001);

        // signed slt with rd destination
        clear_inputs();
        ALUOp_in = 2'b10; Inst_5_to_0_in = 6'b101010; RDdata1_in = 32'hFFFFFFFF;
        RDdata2_in = 32'd1; RegDst_in = 1'b1; Inst_15_to_11_in = 5'd9; Inst_20_to_16_in = 5'd3;
        exec_check("slt");
        check("slt.const", ALU_result_out, 32'd1);
        check("slt.wr", {27'b0, WriteReg_out}, 32'd9);

        // funct 011000 A=3 B=4
        clear_inputs();
        ALUOp_in = 2'b10; Inst_5_to_0_in = 6'b011000; RDdata1_in = 32'd3; RDdata2_in = 32'd4;
`ifdef EX_STAGE_MULT_EN
        run_mult("m34", 32'd3, 32'd4);
        run_mult("mul", 32'h00010003, 32'h00020005);
        check("mul.const", ALU_result_out, 32'h000B000F);
        run_mult("b2b", $urandom, $urandom);
        run_mult("mmax", 32'hFFFFFFFF, 32'hFFFFFFFF);

        // reset in the middle of a multiply
        clear_inputs();
        ALUOp_in = 2'b10; Inst_5_to_0_in = 6'b011000; RDdata1_in = 32'd7; RDdata2_in = 32'd9;
        WB_in = 2'b11; M_in = 2'b11;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy", {31'b0, stall_out}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort.stall", {31'b0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        check("abort.out", {23'b0, WB_out, M_out, WriteReg_out}, 32'd0);
        check("abort.res", ALU_result_out | store_data_out, 32'd0);
        check("abort.zero", {31'b0, Zero_out}, 32'd0);
        reset = 1'b1;
        clear_inputs();
        RDdata1_in = 32'd2; RDdata2_in = 32'd3;
        exec_check("post");
        check("post.const", ALU_result_out, 32'd5);
`else
        exec_check("nomul");
        check("nomul.const", ALU_result_out, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("nomul.stall", {31'b0, stall_out}, 32'd0);
        end
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            WB_in = 2'($urandom); M_in = 2'($urandom);
            ALUSrc_in = 1'($urandom); ALUOp_in = 2'($urandom); RegDst_in = 1'($urandom);
            RDdata1_in = $urandom; RDdata2_in = $urandom; sign_extended_in = $urandom;
            Inst_20_to_16_in = 5'($urandom); Inst_15_to_11_in = 5'($urandom);
            Inst_5_to_0_in = functs[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) Inst_5_to_0_in = 6'($urandom);
`ifdef EX_STAGE_MULT_EN
            if (Inst_5_to_0_in == 6'b011000) Inst_5_to_0_in = 6'b100000;
`endif
            fwdA_in = 2'($urandom); fwdB_in = 2'($urandom);
            exmem_fwd_data_in = $urandom; memwb_fwd_data_in = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                RDdata2_in = RDdata1_in;
                fwdA_in = 2'b00; fwdB_in = 2'b00; ALUSrc_in = 1'b0;
            end
            exec_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
